// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store; one transaction in flight.
// Latency: store ack 2 cycles after request is seen, load ack 2+RD_LAT; requests are levels held until ack.
module mem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [WIDTH-1:0]  if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WIDTH-1:0]  d_wdata,
    output logic              d_ack,
    output logic [WIDTH-1:0]  d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic [WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic               grant_data;

    // owner_q doubles as last_owner: on a tie the requester that did not go last wins
    assign grant_data = d_req && (!if_req || (owner_q == OWN_FETCH));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_DATA;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    state_d = S_ISSUE;
                    if (grant_data) begin
                        owner_d     = OWN_DATA;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_we_d    = d_we;
                    end else begin
                        owner_d     = OWN_FETCH;
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                // mem_we_q is high here only for a store, so it also selects the path
                mem_we_d = 1'b0;
                if (mem_we_q) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign if_ack    = (state_q == S_ACK) && (owner_q == OWN_FETCH);
    assign d_ack     = (state_q == S_ACK) && (owner_q == OWN_DATA);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses RD_LAT=2, instance b uses RD_LAT=1.
// Inputs are driven and outputs sampled on the falling edge; cycle c=0 is the IDLE cycle that sees a request.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        a_if_req, a_if_ack, a_d_req, a_d_we, a_d_ack, a_mem_we, a_busy;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_we, b_busy;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WIDTH(32), .ADDR_W(32), .RD_LAT(2)) u_a (
        .clk(clk), .rstn(rstn),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.WIDTH(32), .ADDR_W(32), .RD_LAT(1)) u_b (
        .clk(clk), .rstn(rstn),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory contents: word 0x10 holds 0xDEADBEEF, every other address a returns 0x10000000|a[7:0]
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a[7:0] == 8'h10) ? 32'hDEADBEEF : (32'h1000_0000 | {24'h0, a[7:0]});
    endfunction

    logic [31:0] a_p1, a_p2, b_p1;
    always @(posedge clk) begin
        a_p1 <= mem_word(a_mem_addr);
        a_p2 <= a_p1;
        b_p1 <= mem_word(b_mem_addr);
    end
    assign a_mem_rdata = a_p2;
    assign b_mem_rdata = b_p1;

    task automatic test_reset();
        rstn = 1'b0;
        a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
        repeat (2) @(negedge clk);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
        total++; if (a_if_ack !== 1'b0 || a_d_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b want=00", a_if_ack, a_d_ack); end
        total++; if (a_mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", a_mem_we); end
        total++; if (a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h want=0/0", a_mem_addr, a_mem_wdata); end
        total++; if (a_if_rdata !== 32'h0 || a_d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", a_if_rdata, a_d_rdata); end
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_b got=%b want=0", b_busy); end
        rstn = 1'b1;
        @(negedge clk);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", a_busy); end
    endtask

    task automatic test_fetch();
        int stray = 0;
        a_if_addr = 32'h10; a_if_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++; if (a_mem_addr !== 32'h10 || a_mem_we !== 1'b0) begin bad++; $display("FAIL fetch_issue got addr=%h we=%b want addr=10 we=0", a_mem_addr, a_mem_we); end
            end
            total++; if (a_if_ack !== (c == 4)) begin bad++; $display("FAIL fetch_ack c=%0d got=%b want=%b", c, a_if_ack, (c == 4)); end
            if (a_d_ack) stray++;
            if (c == 4) a_if_req = 1'b0;
        end
        total++; if (a_if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", a_if_rdata); end
        total++; if (stray != 0) begin bad++; $display("FAIL fetch_stray_dack got=%0d want=0", stray); end
    endtask

    task automatic test_load();
        a_d_addr = 32'h30; a_d_we = 1'b0; a_d_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++; if (a_d_ack !== (c == 4)) begin bad++; $display("FAIL load_ack c=%0d got=%b want=%b", c, a_d_ack, (c == 4)); end
            if (c == 4) a_d_req = 1'b0;
        end
        total++; if (a_d_rdata !== 32'h1000_0030) begin bad++; $display("FAIL load_rdata got=%h want=10000030", a_d_rdata); end
        total++; if (a_if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_if_rdata_kept got=%h want=deadbeef", a_if_rdata); end
    endtask

    task automatic test_store();
        a_d_addr = 32'h20; a_d_wdata = 32'h1234; a_d_we = 1'b1; a_d_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            total++; if (a_mem_we !== (c == 1)) begin bad++; $display("FAIL store_we c=%0d got=%b want=%b", c, a_mem_we, (c == 1)); end
            if (c == 1) begin
                total++; if (a_mem_addr !== 32'h20 || a_mem_wdata !== 32'h1234) begin bad++; $display("FAIL store_bus got=%h/%h want=20/1234", a_mem_addr, a_mem_wdata); end
            end
            total++; if (a_d_ack !== (c == 2)) begin bad++; $display("FAIL store_ack c=%0d got=%b want=%b", c, a_d_ack, (c == 2)); end
            if (c == 2) a_d_req = 1'b0;
        end
        a_d_we = 1'b0;
        total++; if (a_d_rdata !== 32'h1000_0030) begin bad++; $display("FAIL store_rdata_kept got=%h want=10000030", a_d_rdata); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int who [0:2];
        int when [0:2];
        int both = 0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        a_if_addr = 32'h10; a_d_addr = 32'h30; a_d_we = 1'b0;
        a_if_req = 1'b1; a_d_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_if_ack && a_d_ack) both++;
            if (a_if_ack || a_d_ack) begin
                if (n < 3) begin
                    who[n]  = a_d_ack ? 1 : 0;
                    when[n] = c;
                end
                n++;
                if (n == 3) begin a_if_req = 1'b0; a_d_req = 1'b0; end
            end
        end
        a_if_req = 1'b0; a_d_req = 1'b0;
        total++; if (n != 3) begin bad++; $display("FAIL rr_count got=%0d want=3", n); end
        total++; if (both != 0) begin bad++; $display("FAIL rr_overlap got=%0d want=0", both); end
        if (n >= 3) begin
            total++; if (who[0] != 0 || who[1] != 1 || who[2] != 0) begin bad++; $display("FAIL rr_order got=%0d%0d%0d want=010", who[0], who[1], who[2]); end
            total++; if (when[0] != 4 || when[1] != 9 || when[2] != 14) begin bad++; $display("FAIL rr_timing got=%0d,%0d,%0d want=4,9,14", when[0], when[1], when[2]); end
        end
    endtask

    task automatic test_reset_abort();
        int acks = 0;
        a_d_addr = 32'h30; a_d_we = 1'b0; a_d_req = 1'b1;
        @(negedge clk);
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL abort_issue_busy got=%b want=1", a_busy); end
        @(negedge clk);
        if (a_d_ack) acks++;
        rstn = 1'b0; a_d_req = 1'b0;
        @(negedge clk);
        total++; if (a_busy !== 1'b0 || a_mem_we !== 1'b0) begin bad++; $display("FAIL abort_state got busy=%b we=%b want 0/0", a_busy, a_mem_we); end
        total++; if (a_d_rdata !== 32'h0 || a_if_rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata got=%h/%h want=0/0", a_d_rdata, a_if_rdata); end
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (a_d_ack) acks++;
            @(negedge clk);
        end
        total++; if (acks != 0) begin bad++; $display("FAIL abort_no_ack got=%0d want=0", acks); end
        a_d_addr = 32'h34; a_d_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++; if (a_d_ack !== (c == 4)) begin bad++; $display("FAIL abort_reload_ack c=%0d got=%b want=%b", c, a_d_ack, (c == 4)); end
            if (c == 4) a_d_req = 1'b0;
        end
        total++; if (a_d_rdata !== 32'h1000_0034) begin bad++; $display("FAIL abort_reload_rdata got=%h want=10000034", a_d_rdata); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        a_d_addr = 32'h24; a_d_wdata = 32'hCAFE; a_d_we = 1'b1; a_d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (a_d_ack) acks++;
            total++; if (a_d_ack !== (c == 2 || c == 5)) begin bad++; $display("FAIL b2b_ack c=%0d got=%b want=%b", c, a_d_ack, (c == 2 || c == 5)); end
            total++; if (a_mem_we !== (c == 1 || c == 4)) begin bad++; $display("FAIL b2b_we c=%0d got=%b want=%b", c, a_mem_we, (c == 1 || c == 4)); end
            if (c == 5) a_d_req = 1'b0;
        end
        a_d_we = 1'b0;
        total++; if (acks != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", acks); end
    endtask

    task automatic test_rdlat1();
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL lat1_busy c=0 got=%b want=0", b_busy); end
        b_d_addr = 32'h44; b_d_we = 1'b0; b_d_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++; if (b_mem_addr !== 32'h44) begin bad++; $display("FAIL lat1_addr got=%h want=44", b_mem_addr); end
            end
            total++; if (b_busy !== (c >= 1 && c <= 3)) begin bad++; $display("FAIL lat1_busy c=%0d got=%b want=%b", c, b_busy, (c >= 1 && c <= 3)); end
            total++; if (b_d_ack !== (c == 3)) begin bad++; $display("FAIL lat1_ack c=%0d got=%b want=%b", c, b_d_ack, (c == 3)); end
            if (c == 3) b_d_req = 1'b0;
        end
        total++; if (b_d_rdata !== 32'h1000_0044) begin bad++; $display("FAIL lat1_rdata got=%h want=10000044", b_d_rdata); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_round_robin();
        test_reset_abort();
        test_back_to_back();
        test_rdlat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
